unimaster: RTL and testbench
============================

UNIMASTER -- requirements
Module: unimaster

Interface
REQ-001 SHALL have parameter SETTLE, default 8, clock cycles of address/data deskew before MSYN assertion and after SSYN.
REQ-002 SHALL have parameter TMOCYC, default 1000, clock cycles to wait for SSYN before declaring bus timeout.
REQ-003 SHALL have ports: CLOCK in 1, sole clock; RESET_N in 1, reset (asynchronous, active-low).
REQ-004 SHALL have ports: armwrite in 1; armraddr, armwaddr in 3 each; armwdata in 32; armrdata out 32, combinational register read.
REQ-005 SHALL have Unibus inputs: d_in_h 16, ssyn_in_h 1, init_in_h 1, npg_in_h 1, bbsy_in_h 1.
REQ-006 SHALL have Unibus outputs (registered): a_out_h 18, c_out_h 2, d_out_h 16, msyn_out_h, npr_out_h, sack_out_h, bbsy_out_h (1 each).

Function
REQ-007 armrdata SHALL be: reg0 32'h554D2001 ('UM', version 1); reg1 {busy, cfunc[1:0], tmo, abort, 9'b0, addr[17:0]}; reg2 {16'b0, data[15:0]}; others 32'hDEADBEEF.
REQ-008 Write to reg1 while idle SHALL latch cfunc=armwdata[30:29] and addr=armwdata[17:0], clear tmo/abort, and start a cycle if armwdata[31]=1; writes to reg1 while busy SHALL be ignored.
REQ-009 Write to reg2 while idle SHALL latch data=armwdata[15:0]; ignored while busy.
REQ-010 States SHALL be IDLE, REQ, WAITSACK, ADDR, MSYN, HOLD, END.
REQ-011 REQ: assert npr_out_h; on npg_in_h go WAITSACK.
REQ-012 WAITSACK: assert sack_out_h, drop npr_out_h; when npg_in_h, bbsy_in_h, ssyn_in_h all low, assert bbsy_out_h, drive a_out_h=addr, c_out_h=cfunc, d_out_h=data if cfunc[1] else 0, go ADDR.
REQ-013 ADDR: count SETTLE cycles, then assert msyn_out_h, drop sack_out_h, go MSYN.
REQ-014 MSYN: on ssyn_in_h go HOLD; if timeout feature enabled and TMOCYC cycles elapse, set tmo, go END.
REQ-015 HOLD: count SETTLE cycles; for DATI/DATIP (cfunc[1]=0) latch data=d_in_h on last count; then drop msyn_out_h, go END.
REQ-016 END: drop msyn_out_h; when ssyn_in_h low (or immediately if tmo set), zero a_out_h/c_out_h/d_out_h, drop bbsy_out_h, go IDLE.
REQ-017 busy SHALL read 1 in every state except IDLE.
REQ-018 init_in_h high in any non-IDLE state SHALL deassert all Unibus outputs within one cycle, set abort, go IDLE; in IDLE, a start SHALL be held off until init_in_h low.
REQ-019 Byte writes (cfunc=3) SHALL drive data unmodified; byte lane selection is by a_out_h[0].

Reset
REQ-020 RESET_N low SHALL asynchronously force IDLE, all Unibus outputs 0, cfunc/addr/data 0, tmo/abort 0, counters 0.
REQ-021 Register writes during RESET_N low SHALL be ignored.

Configuration
REQ-022 With UNIMASTER_TIMEOUT_EN defined, the MSYN timeout counter and tmo bit SHALL exist; without it, MSYN waits indefinitely for SSYN and tmo reads 0.

Structure
REQ-023 State encoding, register indices, ID constant, and cfunc codes (DATI=0, DATIP=1, DATO=2, DATOB=3) SHALL live in shared package unibus_pkg.
REQ-024 A sub-module unimaster_cnt (loadable down-counter, done flag) SHALL serve SETTLE and TMOCYC timing.

Verification
REQ-025 DATI: addr=0o1000, slave returns 16'o123456 with SSYN after 20 cycles -> reg2 reads 0o123456, busy clears, no tmo.
REQ-026 DATO: data=16'hA5A5, addr=0o2000 -> d_out_h=A5A5 and c_out_h=2 stable SETTLE cycles before msyn_out_h rises.
REQ-027 No SSYN with UNIMASTER_TIMEOUT_EN -> tmo=1 after 1000 cycles in MSYN, bbsy_out_h released.
REQ-028 npg_in_h delayed 50 cycles, bbsy_in_h held high 10 more -> bbsy_out_h asserts only after bbsy_in_h falls.
REQ-029 init_in_h pulsed during MSYN -> all outputs 0 next cycle, abort=1, busy=0.
REQ-030 RESET_N low mid-cycle -> outputs 0 asynchronously; reg1 write while busy -> ignored.

Source files
------------

// File: rtl/unibus_pkg.sv
// Shared Unibus master definitions: FSM states, CSR indices, ID word and bus cycle codes.
package unibus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAITSACK,
        S_ADDR,
        S_MSYN,
        S_HOLD,
        S_END
    } state_t;

    typedef enum logic [1:0] {
        CF_DATI  = 2'd0,
        CF_DATIP = 2'd1,
        CF_DATO  = 2'd2,
        CF_DATOB = 2'd3
    } cfunc_t;

    localparam logic [2:0]  REG_ID   = 3'd0;
    localparam logic [2:0]  REG_CSR  = 3'd1;
    localparam logic [2:0]  REG_DATA = 3'd2;
    localparam logic [31:0] ID_WORD  = 32'h554D2001;
    localparam logic [31:0] BAD_REG  = 32'hDEADBEEF;

    // Counter width able to hold the larger of the two timing loads.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/unimaster_cnt.sv
// Loadable down-counter; done is high once the count has reached zero.
module unimaster_cnt #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/unimaster.sv
// Unibus NPR bus master driven by a small ARM-side register file.
// Define UNIMASTER_TIMEOUT_EN to enable the MSYN/SSYN timeout and the tmo status bit.
module unimaster
    import unibus_pkg::*;
#(
    parameter int SETTLE = 8,
    parameter int TMOCYC = 1000
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        armwrite,
    input  logic [2:0]  armraddr,
    input  logic [2:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic [15:0] d_in_h,
    input  logic        ssyn_in_h,
    input  logic        init_in_h,
    input  logic        npg_in_h,
    input  logic        bbsy_in_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h,
    output logic        msyn_out_h,
    output logic        npr_out_h,
    output logic        sack_out_h,
    output logic        bbsy_out_h
);

`ifdef UNIMASTER_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int            CW        = cnt_width(SETTLE, TMOCYC);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
    localparam logic [CW-1:0] TMO_LD    = CW'(TMOCYC - 1);

    state_t      state_q, state_d;
    cfunc_t      cfunc_q, cfunc_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        tmo_q, tmo_d;
    logic        abort_q, abort_d;
    logic        start_pend_q, start_pend_d;
    logic [17:0] a_out_q, a_out_d;
    logic [1:0]  c_out_q, c_out_d;
    logic [15:0] d_out_q, d_out_d;
    logic        msyn_q, msyn_d;
    logic        npr_q, npr_d;
    logic        sack_q, sack_d;
    logic        bbsy_q, bbsy_d;

    logic          cnt_load, cnt_en, cnt_done;
    logic [CW-1:0] cnt_val;
    logic          busy, csr_wr, data_wr;
    logic          unused_wdata;

    assign unused_wdata = ^armwdata[28:18];
    assign busy    = (state_q != S_IDLE);
    assign csr_wr  = armwrite && (armwaddr == REG_CSR) && !busy;
    assign data_wr = armwrite && (armwaddr == REG_DATA) && !busy;

    unimaster_cnt #(.WIDTH(CW)) u_cnt (
        .clk      (CLOCK),
        .rst_n    (RESET_N),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .done     (cnt_done)
    );

    always_comb begin
        state_d      = state_q;
        cfunc_d      = cfunc_q;
        addr_d       = addr_q;
        data_d       = data_q;
        tmo_d        = tmo_q;
        abort_d      = abort_q;
        start_pend_d = start_pend_q;
        a_out_d      = a_out_q;
        c_out_d      = c_out_q;
        d_out_d      = d_out_q;
        msyn_d       = msyn_q;
        npr_d        = npr_q;
        sack_d       = sack_q;
        bbsy_d       = bbsy_q;
        cnt_load     = 1'b0;
        cnt_val      = SETTLE_LD;
        cnt_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (csr_wr) begin
                    cfunc_d      = cfunc_t'(armwdata[30:29]);
                    addr_d       = armwdata[17:0];
                    tmo_d        = 1'b0;
                    abort_d      = 1'b0;
                    start_pend_d = armwdata[31];
                end
                if (data_wr) begin
                    data_d = armwdata[15:0];
                end
                // A start requested while INIT is asserted waits here until INIT drops.
                if (start_pend_d && !init_in_h) begin
                    start_pend_d = 1'b0;
                    npr_d        = 1'b1;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (npg_in_h) begin
                    npr_d   = 1'b0;
                    sack_d  = 1'b1;
                    state_d = S_WAITSACK;
                end
            end
            S_WAITSACK: begin
                if (!npg_in_h && !bbsy_in_h && !ssyn_in_h) begin
                    bbsy_d   = 1'b1;
                    a_out_d  = addr_q;
                    c_out_d  = cfunc_q;
                    d_out_d  = cfunc_q[1] ? data_q : 16'h0000;
                    cnt_load = 1'b1;
                    cnt_val  = SETTLE_LD;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_en = 1'b1;
                if (cnt_done) begin
                    msyn_d   = 1'b1;
                    sack_d   = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = TMO_LD;
                    state_d  = S_MSYN;
                end
            end
            S_MSYN: begin
                cnt_en = 1'b1;
                if (ssyn_in_h) begin
                    cnt_load = 1'b1;
                    cnt_val  = SETTLE_LD;
                    state_d  = S_HOLD;
                end else if (TIMEOUT_EN && cnt_done) begin
                    tmo_d   = 1'b1;
                    msyn_d  = 1'b0;
                    state_d = S_END;
                end
            end
            S_HOLD: begin
                cnt_en = 1'b1;
                if (cnt_done) begin
                    if (!cfunc_q[1]) begin
                        data_d = d_in_h;
                    end
                    msyn_d  = 1'b0;
                    state_d = S_END;
                end
            end
            S_END: begin
                msyn_d = 1'b0;
                if (!ssyn_in_h || tmo_q) begin
                    a_out_d = '0;
                    c_out_d = '0;
                    d_out_d = '0;
                    bbsy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus INIT aborts any cycle in progress and releases the bus.
        if (busy && init_in_h) begin
            a_out_d      = '0;
            c_out_d      = '0;
            d_out_d      = '0;
            msyn_d       = 1'b0;
            npr_d        = 1'b0;
            sack_d       = 1'b0;
            bbsy_d       = 1'b0;
            abort_d      = 1'b1;
            start_pend_d = 1'b0;
            cnt_load     = 1'b0;
            state_d      = S_IDLE;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            cfunc_q      <= CF_DATI;
            addr_q       <= '0;
            data_q       <= '0;
            tmo_q        <= 1'b0;
            abort_q      <= 1'b0;
            start_pend_q <= 1'b0;
            a_out_q      <= '0;
            c_out_q      <= '0;
            d_out_q      <= '0;
            msyn_q       <= 1'b0;
            npr_q        <= 1'b0;
            sack_q       <= 1'b0;
            bbsy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfunc_q      <= cfunc_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            tmo_q        <= tmo_d;
            abort_q      <= abort_d;
            start_pend_q <= start_pend_d;
            a_out_q      <= a_out_d;
            c_out_q      <= c_out_d;
            d_out_q      <= d_out_d;
            msyn_q       <= msyn_d;
            npr_q        <= npr_d;
            sack_q       <= sack_d;
            bbsy_q       <= bbsy_d;
        end
    end

    always_comb begin
        case (armraddr)
            REG_ID:   armrdata = ID_WORD;
            REG_CSR:  armrdata = {busy, cfunc_q, tmo_q, abort_q, 9'b0, addr_q};
            REG_DATA: armrdata = {16'h0000, data_q};
            default:  armrdata = BAD_REG;
        endcase
    end

    assign a_out_h    = a_out_q;
    assign c_out_h    = c_out_q;
    assign d_out_h    = d_out_q;
    assign msyn_out_h = msyn_q;
    assign npr_out_h  = npr_q;
    assign sack_out_h = sack_q;
    assign bbsy_out_h = bbsy_q;

endmodule

// File: tb/tb_unimaster.sv
// Directed self-checking bench for unimaster: register table plus DATI/DATO/arbitration/INIT/timeout/reset sequences.
module tb_unimaster;

    logic        CLOCK, RESET_N;
    logic        armwrite;
    logic [2:0]  armraddr, armwaddr;
    logic [31:0] armwdata, armrdata;
    logic [15:0] d_in_h;
    logic        ssyn_in_h, init_in_h, npg_in_h, bbsy_in_h;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h;
    logic        msyn_out_h, npr_out_h, sack_out_h, bbsy_out_h;

    int checks = 0;
    int errors = 0;

    unimaster #(.SETTLE(8), .TMOCYC(1000)) dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .armwrite   (armwrite),
        .armraddr   (armraddr),
        .armwaddr   (armwaddr),
        .armwdata   (armwdata),
        .armrdata   (armrdata),
        .d_in_h     (d_in_h),
        .ssyn_in_h  (ssyn_in_h),
        .init_in_h  (init_in_h),
        .npg_in_h   (npg_in_h),
        .bbsy_in_h  (bbsy_in_h),
        .a_out_h    (a_out_h),
        .c_out_h    (c_out_h),
        .d_out_h    (d_out_h),
        .msyn_out_h (msyn_out_h),
        .npr_out_h  (npr_out_h),
        .sack_out_h (sack_out_h),
        .bbsy_out_h (bbsy_out_h)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        wr;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        armwrite = 1'b1;
        armwaddr = a;
        armwdata = d;
        tick();
        armwrite = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        armraddr = a;
        #1;
        d = armrdata;
    endtask

    task automatic grant();
        npg_in_h = 1'b1;
        tick();
        npg_in_h = 1'b0;
        tick();
    endtask

    task automatic wait_msyn(input logic level, input int bound, output int n);
        n = 0;
        while (msyn_out_h !== level && n < bound) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int n;

        vecs[0] = '{1'b0, 3'd0, 32'h0,          3'd0, 32'h554D2001};
        vecs[1] = '{1'b0, 3'd0, 32'h0,          3'd1, 32'h00000000};
        vecs[2] = '{1'b0, 3'd0, 32'h0,          3'd2, 32'h00000000};
        vecs[3] = '{1'b0, 3'd0, 32'h0,          3'd3, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 3'd0, 32'h0,          3'd7, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 3'd1, 32'h5FFFFFFF,   3'd1, 32'h4003FFFF};
        vecs[6] = '{1'b1, 3'd2, 32'hFFFF1234,   3'd2, 32'h00001234};
        vecs[7] = '{1'b1, 3'd0, 32'h12345678,   3'd0, 32'h554D2001};
        vecs[8] = '{1'b1, 3'd1, 32'h60000000,   3'd1, 32'h60000000};

        RESET_N = 1'b0;
        armwrite = 1'b0; armraddr = 3'd0; armwaddr = 3'd0; armwdata = 32'h0;
        d_in_h = 16'h0; ssyn_in_h = 1'b0; init_in_h = 1'b0; npg_in_h = 1'b0; bbsy_in_h = 1'b0;
        repeat (3) tick();
        RESET_N = 1'b1;
        tick();
        check("reset_outputs", {a_out_h, c_out_h, d_out_h, msyn_out_h, npr_out_h, sack_out_h, bbsy_out_h}, 32'h0);

        // Register file table
        for (int i = 0; i < 9; i++) begin
            armwrite = vecs[i].wr;
            armwaddr = vecs[i].waddr;
            armwdata = vecs[i].wdata;
            armraddr = vecs[i].raddr;
            tick();
            armwrite = 1'b0;
            check($sformatf("vec%0d_rd%0d", i, vecs[i].raddr), armrdata, vecs[i].exp);
        end
        check("no_start_npr", {31'b0, npr_out_h}, 32'h0);

        // DATI from 0o1000, slave answers 20 cycles after MSYN
        wr(3'd1, 32'h80000200);
        check("dati_npr", {31'b0, npr_out_h}, 32'h1);
        rd(3'd1, r);
        check("dati_busy", r, 32'h80000200);
        npg_in_h = 1'b1;
        tick();
        check("dati_sack_npr", {30'b0, sack_out_h, npr_out_h}, 32'h2);
        npg_in_h = 1'b0;
        tick();
        check("dati_addr", {13'b0, bbsy_out_h, a_out_h}, {13'b0, 1'b1, 18'o1000});
        check("dati_ctl_data", {14'b0, c_out_h, d_out_h}, 32'h0);
        wait_msyn(1'b1, 20, n);
        check("dati_msyn_up", {31'b0, msyn_out_h}, 32'h1);
        repeat (20) tick();
        d_in_h = 16'o123456;
        ssyn_in_h = 1'b1;
        wait_msyn(1'b0, 30, n);
        check("dati_msyn_down", {31'b0, msyn_out_h}, 32'h0);
        rd(3'd1, r);
        check("dati_end_busy", {r[31], 30'b0, bbsy_out_h}, 32'h80000001);
        ssyn_in_h = 1'b0;
        d_in_h = 16'h0;
        tick();
        check("dati_release", {13'b0, bbsy_out_h, a_out_h}, 32'h0);
        rd(3'd2, r);
        check("dati_data", r, 32'h0000A72E);
        rd(3'd1, r);
        check("dati_csr", r, 32'h00000200);

        // DATO of A5A5 to 0o2000: data and function must lead MSYN by 8 cycles
        wr(3'd2, 32'h0000A5A5);
        wr(3'd1, 32'hC0000400);
        grant();
        check("dato_dout", {14'b0, c_out_h, d_out_h}, {14'b0, 2'd2, 16'hA5A5});
        check("dato_addr", {14'b0, a_out_h}, 32'h00000400);
        wait_msyn(1'b1, 20, n);
        check("dato_settle", n, 32'd8);
        check("dato_hold_dout", {14'b0, c_out_h, d_out_h}, {14'b0, 2'd2, 16'hA5A5});
        check("dato_sack_drop", {31'b0, sack_out_h}, 32'h0);
        ssyn_in_h = 1'b1;
        wait_msyn(1'b0, 30, n);
        ssyn_in_h = 1'b0;
        tick();
        check("dato_release", {14'b0, bbsy_out_h, d_out_h}, 32'h0);
        rd(3'd2, r);
        check("dato_data_kept", r, 32'h0000A5A5);

        // Grant late by 50 cycles, another master holds BBSY 10 more
        wr(3'd1, 32'h80000600);
        repeat (50) tick();
        check("arb_wait_npr", {30'b0, npr_out_h, sack_out_h}, 32'h2);
        npg_in_h = 1'b1;
        bbsy_in_h = 1'b1;
        tick();
        npg_in_h = 1'b0;
        repeat (10) tick();
        check("arb_bbsy_held", {30'b0, sack_out_h, bbsy_out_h}, 32'h2);
        bbsy_in_h = 1'b0;
        tick();
        check("arb_bbsy_taken", {31'b0, bbsy_out_h}, 32'h1);

        // INIT during MSYN aborts the cycle
        wait_msyn(1'b1, 20, n);
        check("init_msyn_up", {31'b0, msyn_out_h}, 32'h1);
        init_in_h = 1'b1;
        tick();
        check("init_outputs", {a_out_h, c_out_h, d_out_h, msyn_out_h, npr_out_h, sack_out_h, bbsy_out_h}, 32'h0);
        rd(3'd1, r);
        check("init_csr", r, 32'h08000600);

        // Start held off while INIT high
        wr(3'd1, 32'h80000800);
        check("holdoff_npr", {31'b0, npr_out_h}, 32'h0);
        rd(3'd1, r);
        check("holdoff_csr", r, 32'h00000800);
        init_in_h = 1'b0;
        tick();
        check("holdoff_start", {31'b0, npr_out_h}, 32'h1);

        // No SSYN from any slave
        grant();
        wait_msyn(1'b1, 20, n);
        check("tmo_msyn_up", {31'b0, msyn_out_h}, 32'h1);
`ifdef UNIMASTER_TIMEOUT_EN
        wait_msyn(1'b0, 1100, n);
        check("tmo_cycles", n, 32'd1000);
        tick();
        check("tmo_bbsy", {31'b0, bbsy_out_h}, 32'h0);
        rd(3'd1, r);
        check("tmo_csr", r, 32'h10000800);
`else
        repeat (1100) tick();
        check("notmo_msyn", {30'b0, msyn_out_h, bbsy_out_h}, 32'h3);
        rd(3'd1, r);
        check("notmo_csr", r, 32'h80000800);
        init_in_h = 1'b1;
        tick();
        init_in_h = 1'b0;
        rd(3'd1, r);
        check("notmo_abort_csr", r, 32'h08000800);
`endif

        // Writes while busy ignored, then asynchronous reset mid-cycle
        wr(3'd2, 32'h00005A5A);
        wr(3'd1, 32'hC0000010);
        grant();
        check("busy_bbsy", {31'b0, bbsy_out_h}, 32'h1);
        wr(3'd1, 32'h00000777);
        rd(3'd1, r);
        check("busy_csr_ignored", r, 32'hC0000010);
        wr(3'd2, 32'h00001111);
        rd(3'd2, r);
        check("busy_data_ignored", r, 32'h00005A5A);
        #1;
        RESET_N = 1'b0;
        #1;
        check("async_reset_outputs", {a_out_h, c_out_h, d_out_h, msyn_out_h, npr_out_h, sack_out_h, bbsy_out_h}, 32'h0);
        wr(3'd2, 32'h0000FFFF);
        rd(3'd2, r);
        check("reset_write_ignored", r, 32'h0);
        RESET_N = 1'b1;
        tick();
        rd(3'd1, r);
        check("reset_csr", r, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
